// File: rtl/cook_timer_pkg.sv
// cook_timer_pkg
//   Shared widths and constants for the cook timer: BCD digit width, digit
//   count, and the per-digit reload value used when a digit borrows.
//   digit_max() returns the reload value for a digit position
//   (0 = sec_ones ... 3 = min_tens).
package cook_timer_pkg;

    localparam int unsigned BCD_W        = 4;
    localparam int unsigned NUM_DIGITS   = 4;
    localparam int unsigned SEC_TENS_IDX = 1;

    localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    function automatic logic [BCD_W-1:0] digit_max(input int unsigned idx);
        return (idx == SEC_TENS_IDX) ? SEC_TENS_MAX : BCD_MAX;
    endfunction

endpackage

// File: rtl/cook_timer_bcd_dec_digit.sv
// bcd_dec_digit
//   One stage of the BCD decrement borrow chain.
//   d          in   current digit value
//   max        in   value loaded when the digit underflows
//   borrow_in  in   request to decrement this digit
//   q          out  digit value after the (optional) decrement
//   borrow_out out  this digit was 0 and borrowed from the next stage
module bcd_dec_digit
    import cook_timer_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    input  logic [BCD_W-1:0] max,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out
);

    always_comb begin
        q          = d;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (d == '0) begin
                q          = max;
                borrow_out = 1'b1;
            end else begin
                q = d - BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/cook_timer.sv
// cook_timer
//   Microwave countdown timer. Keypad digits shift into a 4-digit BCD MM:SS
//   register; while the magnetron runs the count decrements once per
//   TICK_DIV clock cycles until it reaches 00:00.
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   clearn       in   active-low synchronous clear of count and prescaler
//   digit_valid  in   one-cycle keypad strobe
//   digit        in   BCD keypad digit (values >9 are ignored)
//   mag_on       in   magnetron running; enables the countdown
//   min_tens..sec_ones out  displayed BCD digits
//   timer_done   out  count is 00:00 (decoded from registers only)
//   tick         out  one-cycle pulse in the cycle whose edge decrements
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PW       = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clearn,
    input  logic             digit_valid,
    input  logic [BCD_W-1:0] digit,
    input  logic             mag_on,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             timer_done,
    output logic             tick
);

    // Index 0 is sec_ones, index NUM_DIGITS-1 is min_tens.
    logic [NUM_DIGITS-1:0][BCD_W-1:0] cnt_q;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] cnt_dec;
    logic [NUM_DIGITS:0]              borrow;
    logic [PW-1:0]                    presc_q;
    logic                             presc_last;
    logic                             run;
    logic                             entry_ok;

    // The chain always computes count-1. A borrow out of the top stage
    // only happens when every digit is zero, so it doubles as the
    // zero-count decode.
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_chain
        bcd_dec_digit u_digit (
            .d          (cnt_q[i]),
            .max        (digit_max(i)),
            .borrow_in  (borrow[i]),
            .q          (cnt_dec[i]),
            .borrow_out (borrow[i+1])
        );
    end

    assign timer_done = borrow[NUM_DIGITS];

    always_comb begin
        run        = mag_on & ~timer_done;
        presc_last = (presc_q == PW'(TICK_DIV - 1));
        entry_ok   = digit_valid & ~mag_on & (digit <= BCD_MAX);
        tick       = clearn & run & presc_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            presc_q <= '0;
        end else if (!clearn) begin
            cnt_q   <= '0;
            presc_q <= '0;
        end else if (entry_ok) begin
            cnt_q   <= {cnt_q[NUM_DIGITS-2:0], digit};
            presc_q <= '0;
        end else if (run) begin
            if (presc_last) begin
                presc_q <= '0;
                cnt_q   <= cnt_dec;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    assign min_tens = cnt_q[3];
    assign min_ones = cnt_q[2];
    assign sec_tens = cnt_q[1];
    assign sec_ones = cnt_q[0];

endmodule

// File: tb/tb_cook_timer.sv
module tb_cook_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clearn = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       mag_on = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: digits m[0..3] = MM:SS left to right, plus a
    // cycle counter within the current second.
    int m[4];
    int m_presc;

    always #5 clk = ~clk;

    cook_timer #(.TICK_DIV(TD), .PW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .clearn      (clearn),
        .digit_valid (digit_valid),
        .digit       (digit),
        .mag_on      (mag_on),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .timer_done  (timer_done),
        .tick        (tick)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_zero();
        return (m[0] == 0 && m[1] == 0 && m[2] == 0 && m[3] == 0);
    endfunction

    function automatic int model_packed();
        return (m[0] << 12) | (m[1] << 8) | (m[2] << 4) | m[3];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 0;
        m_presc = 0;
    endtask

    // One second off MM:SS, seconds counted literally (so 99 -> 98).
    task automatic model_dec();
        int mins, secs;
        mins = m[0] * 10 + m[1];
        secs = m[2] * 10 + m[3];
        if (secs > 0) secs--;
        else begin
            mins--;
            secs = 59;
        end
        m[0] = mins / 10; m[1] = mins % 10;
        m[2] = secs / 10; m[3] = secs % 10;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_cnt"}, 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'(model_packed()));
        check_val({tag, "_done"}, 32'(timer_done), 32'(model_zero()));
    endtask

    // Apply inputs for one clock, check tick before the edge and the
    // register state after it.
    task automatic step(input logic cl, input logic dv, input logic [3:0] dg, input logic mo);
        bit counting, exp_tick;
        clearn = cl; digit_valid = dv; digit = dg; mag_on = mo;
        #1;
        counting = mo && !model_zero();
        exp_tick = cl && counting && (m_presc == TD - 1);
        check_val("tick", 32'(tick), 32'(exp_tick));
        @(posedge clk);
        if (!cl) begin
            model_reset();
        end else if (dv && !mo && dg <= 9) begin
            m[0] = m[1]; m[1] = m[2]; m[2] = m[3]; m[3] = int'(dg);
            m_presc = 0;
        end else if (counting) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                model_dec();
            end else begin
                m_presc++;
            end
        end
        #1;
        check_outputs("step");
    endtask

    task automatic enter(input logic [3:0] dg);
        step(1'b1, 1'b1, dg, 1'b0);
    endtask

    task automatic idle(input logic mo, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, mo);
    endtask

    task automatic clear();
        step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        model_reset();
        #3;
        check_val("rst_cnt", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0);
        check_val("rst_done", 32'(timer_done), 32'h1);
        check_val("rst_tick", 32'(tick), 32'h0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Running at 00:00 must not tick or wrap.
        idle(1'b1, 6);

        enter(4'd1); enter(4'd3); enter(4'd0);
        check_val("entry_130", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0130);
        check_val("entry_130_done", 32'(timer_done), 32'h0);

        clear();
        enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4); enter(4'd5);
        check_val("entry_shift", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h2345);

        // 01:00 -> 00:59 after TD cycles, then ticks every TD cycles.
        clear();
        enter(4'd1); enter(4'd0); enter(4'd0);
        idle(1'b1, 3);
        check_val("pre_first_dec", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0100);
        idle(1'b1, 1);
        check_val("first_dec", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0059);
        idle(1'b1, 9);

        // 00:02 runs to 00:00 and holds.
        clear();
        enter(4'd2);
        idle(1'b1, 8);
        check_val("reach_zero_done", 32'(timer_done), 32'h1);
        idle(1'b1, 8);

        // Pause mid-second.
        clear();
        enter(4'd1); enter(4'd0); enter(4'd0);
        idle(1'b1, 2);
        idle(1'b0, 10);
        check_val("paused", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0100);
        idle(1'b1, 1);
        idle(1'b1, 1);
        check_val("resume_dec", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0059);
        idle(1'b1, 3);

        // Clear beats entry; invalid digit and entry during run ignored.
        clear();
        enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4);
        step(1'b0, 1'b1, 4'd5, 1'b0);
        check_val("clear_prio", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0000);
        enter(4'hA);
        enter(4'd7);
        step(1'b1, 1'b1, 4'd3, 1'b1);
        idle(1'b1, 2);

        // Literal seconds above 59, and 10:00 -> 09:59.
        clear();
        enter(4'd9); enter(4'd9);
        idle(1'b1, 4 * 42);
        clear();
        enter(4'd1); enter(4'd0); enter(4'd0); enter(4'd0);
        idle(1'b1, 4 * 3);

        // Async reset between edges.
        clear();
        enter(4'd9);
        idle(1'b1, 2);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        check_val("async_rst_tick", 32'(tick), 32'h0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        idle(1'b1, 3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic cl, dv, mo;
            logic [3:0] dg;
            if ($urandom_range(0, 11) == 0) mag_on = ~mag_on;
            mo = mag_on;
            cl = ($urandom_range(0, 59) != 0);
            dv = ($urandom_range(0, 4) == 0);
            dg = 4'($urandom_range(0, 15));
            step(cl, dv, dg, mo);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
